// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with same-cycle write bypass
// and a per-register busy scoreboard. Register 0 is hard-wired to zero, and the
// stack/frame registers (29, 30) come out of reset at SP_INIT.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int N_RD    = 2,
  parameter int BYPASS  = 1,
  parameter int SP_INIT = 65536
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [N_RD*ADDR_W-1:0]   ReadRg,
  output logic [N_RD*DATA_W-1:0]   ReadData,
  output logic [N_RD-1:0]          ReadBusy,
  input  logic                     RegWrite0,
  input  logic [ADDR_W-1:0]        WriteRg0,
  input  logic [DATA_W-1:0]        WriteData0,
  input  logic                     RegWrite1,
  input  logic [ADDR_W-1:0]        WriteRg1,
  input  logic [DATA_W-1:0]        WriteData1,
  input  logic                     IssueValid,
  input  logic [ADDR_W-1:0]        IssueRg,
  output logic [ADDR_W:0]          BusyCount
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;
  logic              wrEn0;
  logic              wrEn1;
  logic              issueEn;
  logic              busyRise;
  logic              busyFall0;
  logic              busyFall1;
  logic [ADDR_W:0]   countNext;

  // Writes and issues aimed at register 0 are dropped up front so nothing
  // downstream has to special-case it again.
  assign wrEn0   = RegWrite0  && (WriteRg0 != '0);
  assign wrEn1   = RegWrite1  && (WriteRg1 != '0);
  assign issueEn = IssueValid && (IssueRg  != '0);

  // Register storage: port 1 is written last so it wins an address collision.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == 29 || i == 30) ? DATA_W'(SP_INIT) : '0;
      end
    end else begin
      if (wrEn0) regs[WriteRg0] <= WriteData0;
      if (wrEn1) regs[WriteRg1] <= WriteData1;
    end
  end

  // Next busy vector: completions clear first, then a new issue sets, so a
  // producer issued in the same cycle supersedes the one completing.
  always_comb begin
    busyNext = busy;
    if (wrEn0)   busyNext[WriteRg0] = 1'b0;
    if (wrEn1)   busyNext[WriteRg1] = 1'b0;
    if (issueEn) busyNext[IssueRg]  = 1'b1;
    busyNext[0] = 1'b0;
  end

  // Counter delta from the individual 0->1 and 1->0 transitions; a second
  // write port hitting the same register as the first must not count twice.
  always_comb begin
    busyRise  = issueEn && !busy[IssueRg];
    busyFall0 = wrEn0 && busy[WriteRg0] && !(issueEn && (IssueRg == WriteRg0));
    busyFall1 = wrEn1 && busy[WriteRg1] && !(issueEn && (IssueRg == WriteRg1))
                && !(wrEn0 && (WriteRg0 == WriteRg1));
    countNext = BusyCount
                + {{ADDR_W{1'b0}}, busyRise}
                - {{ADDR_W{1'b0}}, busyFall0}
                - {{ADDR_W{1'b0}}, busyFall1};
  end

  // Scoreboard state: busy bits and the running count of set bits.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy      <= '0;
      BusyCount <= '0;
    end else begin
      busy      <= busyNext;
      BusyCount <= countNext;
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : gRead
    logic [ADDR_W-1:0] rdAddr;
    logic [DATA_W-1:0] rdData;
    logic              rdBusy;
    logic              hit0;
    logic              hit1;

    assign rdAddr = ReadRg[p*ADDR_W +: ADDR_W];
    assign hit0   = (BYPASS != 0) && wrEn0 && (WriteRg0 == rdAddr);
    assign hit1   = (BYPASS != 0) && wrEn1 && (WriteRg1 == rdAddr);

    // Read mux: zero register, then forwarded write data (port 1 first), then storage.
    always_comb begin
      rdData = regs[rdAddr];
      rdBusy = busy[rdAddr];
      if (rdAddr == '0) begin
        rdData = '0;
        rdBusy = 1'b0;
      end else if (hit1) begin
        rdData = WriteData1;
        rdBusy = 1'b0;
      end else if (hit0) begin
        rdData = WriteData0;
        rdBusy = 1'b0;
      end
    end

    assign ReadData[p*DATA_W +: DATA_W] = rdData;
    assign ReadBusy[p]                  = rdBusy;
  end

endmodule
